div_unit: RTL and testbench

- Multi-cycle radix-2 restoring divider for DIV/DIVU, located in the EX stage.
- Takes operands from EX and returns a 64-bit {remainder, quotient} result for the HI/LO write path.
- While a division is in flight, it holds the pipeline by driving stallreq_for_ex into the pipeline control unit, which converts it into the `StallBus stall vector.
- Supports an annul input so that a flushed or cancelled division can be abandoned mid-operation.

---
 rtl/div_unit_pkg.sv | 18 +
 rtl/div_unit_div_step.sv | 21 ++
 rtl/div_unit.sv | 129 ++++++++++++
 tb/tb_div_unit.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/div_unit_pkg.sv
// Shared constants and types for the multi-cycle EX-stage divider.
package div_unit_pkg;

    localparam int unsigned DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic STOP                 = 1'b1;
    localparam logic NO_STOP              = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

endpackage

// File: rtl/div_unit_div_step.sv
// One restoring division iteration: shift in the next dividend bit and trial-subtract.
module div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next_c,
    output logic             q_bit_c
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    // rem < divisor keeps shifted below 2^(WIDTH+1), so bit WIDTH of trial is its sign
    assign shifted    = {rem, bit_in};
    assign trial      = shifted - {1'b0, divisor};
    assign q_bit_c    = ~trial[WIDTH];
    assign rem_next_c = q_bit_c ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/div_unit.sv
// Radix-2 restoring DIV/DIVU unit; stalls EX while busy and returns {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               div_start,
    input  logic               div_signed,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    input  logic               annul,
    output logic               stallreq_for_ex,
    output logic               ready,
    output logic [2*WIDTH-1:0] result
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    div_state_e       state;
    div_state_e       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic             neg_dvd_q;
    logic             neg_dvs_q;

    logic             start_c;
    logic             last_step_c;
    logic [WIDTH-1:0] step_rem_c;
    logic             step_q_c;
    logic [WIDTH-1:0] quo_raw_c;
    logic [WIDTH-1:0] quo_fix_c;
    logic [WIDTH-1:0] rem_fix_c;

    assign start_c     = div_start & ~annul;
    assign last_step_c = (cnt == CNT_W'(WIDTH - 1));

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem        (rem_q),
        .bit_in     (dvd_q[WIDTH-1]),
        .divisor    (dvs_q),
        .rem_next_c (step_rem_c),
        .q_bit_c    (step_q_c)
    );

    // Sign flags are only ever set for signed operations, so no extra gating is needed
    assign quo_raw_c = {dvd_q[WIDTH-2:0], step_q_c};
    assign quo_fix_c = (neg_dvd_q ^ neg_dvs_q) ? (-quo_raw_c) : quo_raw_c;
    assign rem_fix_c = neg_dvd_q ? (-step_rem_c) : step_rem_c;

    assign stallreq_for_ex = (div_start && !annul && (state != DIV_END)) ? STOP : NO_STOP;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= DIV_FREE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            DIV_FREE: begin
                if (start_c) begin
                    state_nxt = (divisor == '0) ? DIV_BY_ZERO : DIV_ON;
                end
            end
            DIV_BY_ZERO: state_nxt = DIV_END;
            DIV_ON: begin
                if (annul) begin
                    state_nxt = DIV_FREE;
                end else if (last_step_c) begin
                    state_nxt = DIV_END;
                end
            end
            DIV_END: state_nxt = DIV_FREE;
            default: state_nxt = DIV_FREE;
        endcase
    end

    // Datapath: operand capture, iteration, and result load on entry to END
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            neg_dvd_q <= 1'b0;
            neg_dvs_q <= 1'b0;
            result    <= '0;
            ready     <= DIV_RESULT_NOT_READY;
        end else begin
            ready <= DIV_RESULT_NOT_READY;
            case (state)
                DIV_FREE: begin
                    if (start_c && (divisor != '0)) begin
                        dvd_q     <= (div_signed && dividend[WIDTH-1]) ? (-dividend) : dividend;
                        dvs_q     <= (div_signed && divisor[WIDTH-1]) ? (-divisor) : divisor;
                        neg_dvd_q <= div_signed & dividend[WIDTH-1];
                        neg_dvs_q <= div_signed & divisor[WIDTH-1];
                        cnt       <= '0;
                        rem_q     <= '0;
                    end
                end
                DIV_BY_ZERO: begin
                    result <= '0;
                    ready  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (!annul) begin
                        dvd_q <= quo_raw_c;
                        rem_q <= step_rem_c;
                        cnt   <= cnt + CNT_W'(1);
                        if (last_step_c) begin
                            result <= {rem_fix_c, quo_fix_c};
                            ready  <= DIV_RESULT_READY;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver queues expected results, negedge monitor checks them.
module tb_div_unit;
    import div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        div_start;
    logic        div_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stallreq_for_ex;
    logic        ready;
    logic [63:0] result;

    typedef struct {
        logic [63:0] res;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    logic [63:0] last_res = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .div_start       (div_start),
        .div_signed      (div_signed),
        .dividend        (dividend),
        .divisor         (divisor),
        .annul           (annul),
        .stallreq_for_ex (stallreq_for_ex),
        .ready           (ready),
        .result          (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every ready pulse must match the oldest queued expectation, in the predicted cycle
    always @(negedge clk) begin
        if (!rst && ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got ready=1 expected none (cycle %0d)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("ready_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    // Called at posedge+1: start an operation, check stall over its lifetime, release after END
    task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int lat);
        exp_t e;
        div_start  = 1'b1;
        div_signed = sgn;
        dividend   = a;
        divisor    = b;
        e.res = exp;
        e.cyc = cyc + lat;
        sb.push_back(e);
        last_res = exp;
        for (int i = 0; i <= lat; i++) begin
            @(negedge clk);
            check("stallreq", 64'(stallreq_for_ex), 64'(i < lat));
        end
        step();
        div_start = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst        = 1'b1;
        div_start  = 1'b0;
        annul      = 1'b0;
        div_signed = 1'b0;
        dividend   = '0;
        divisor    = '0;
        repeat (3) step();
        @(negedge clk);
        check("rst_result", result, 64'h0);
        check("rst_ready", 64'(ready), 64'h0);
        check("rst_stall", 64'(stallreq_for_ex), 64'h0);
        step();
        rst = 1'b0;

        run_op(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        step();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_op(1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 33);
        run_op(1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'd3}, 33);
        run_op(1'b0, 32'h0000_1234, 32'd0, 64'h0, 2);
        run_op(1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 33);

        // Annul at T+10: no ready, result retained, back in IDLE at T+11
        div_start  = 1'b1;
        div_signed = 1'b0;
        dividend   = 32'd1000;
        divisor    = 32'd3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("annul_pre_stall", 64'(stallreq_for_ex), 64'h1);
            step();
        end
        annul = 1'b1;
        @(negedge clk);
        check("annul_stall", 64'(stallreq_for_ex), 64'h0);
        step();
        annul     = 1'b0;
        div_start = 1'b0;
        @(negedge clk);
        check("annul_state", 64'(dut.state), 64'(DIV_FREE));
        repeat (40) step();
        @(negedge clk);
        check("annul_result_kept", result, last_res);
        step();

        // Start and annul together in IDLE: nothing starts
        div_start = 1'b1;
        annul     = 1'b1;
        divisor   = 32'd5;
        @(negedge clk);
        check("start_annul_stall", 64'(stallreq_for_ex), 64'h0);
        step();
        div_start = 1'b0;
        annul     = 1'b0;
        @(negedge clk);
        check("start_annul_state", 64'(dut.state), 64'(DIV_FREE));
        step();

        // Reset at T+5 mid-operation
        div_start = 1'b1;
        dividend  = 32'd1000;
        divisor   = 32'd3;
        repeat (5) step();
        rst       = 1'b1;
        div_start = 1'b0;
        step();
        @(negedge clk);
        check("midrst_ready", 64'(ready), 64'h0);
        check("midrst_result", result, 64'h0);
        check("midrst_state", 64'(dut.state), 64'(DIV_FREE));
        step();
        rst = 1'b0;

        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 33);
        step();
        run_op(1'b0, 32'd20, 32'd3, {32'd2, 32'd6}, 33);
        run_op(1'b0, 32'd9, 32'd9, {32'd0, 32'd1}, 33);

        repeat (5) step();
        check("sb_empty", 64'(sb.size()), 64'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
